roadid_pass_param: RTL and testbench

Parametrised successor to the fixed-width road-ID passthrough in the GigaFitter fit pipeline. Each road's ID and error bits are held in an input FIFO until all of its fit combinations have been processed. When the best combination is selected, the road's ID is copied into an output FIFO, which the track-output formatter reads. Both FIFOs are built from internal RAM and pointers, so the block no longer depends on vendor IP. The block adds occupancy counts, output valid, and sticky overflow/underflow flags.

---
 rtl/roadid_pass_param.sv | 134 +++++++++++++
 tb/tb_roadid_pass_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/roadid_pass_param.sv
// Road-ID passthrough: a first-word-fall-through input FIFO holds each road's
// ID and error bits until its combinations are done, and the best road's head
// entry is copied into a standard output FIFO read by the track formatter.
module roadid_pass_param #(
  parameter int ID_W         = 21,
  parameter int ERR_W        = 2,
  parameter int IN_DEPTH     = 16,
  parameter int OUT_DEPTH    = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                             CLOCK,
  input  logic                             reset_n,
  input  logic                             CE,
  input  logic [ID_W-1:0]                  ROADID_IN,
  input  logic [ERR_W-1:0]                 road_errors_in,
  input  logic                             roadid_we,
  input  logic                             last_comb,
  input  logic                             best,
  input  logic                             roadid_re,
  input  logic                             clr_err,
  output logic [ID_W-1:0]                  ROADID_OUT,
  output logic [ERR_W-1:0]                 road_errors_out,
  output logic                             roadid_valid,
  output logic                             fifo_roadid_afull,
  output logic [$clog2(IN_DEPTH+1)-1:0]    in_count,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   out_count,
  output logic                             overflow_err,
  output logic                             underflow_err
);

  localparam int EW     = ID_W + ERR_W;
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

  logic [ID_W-1:0]   roadid_register;
  logic [EW-1:0]     in_mem  [IN_DEPTH];
  logic [EW-1:0]     out_mem [OUT_DEPTH];
  logic [IN_AW-1:0]  in_wptr, in_rptr;
  logic [OUT_AW-1:0] out_wptr, out_rptr;
  logic [EW-1:0]     in_head;

  logic in_empty, in_full, out_empty, out_full;
  logic do_write, do_pop, do_copy, do_read;
  logic set_overflow, set_underflow;

  // Occupancy status and the accept/drop decision for every request
  always_comb begin
    in_empty      = (in_count == '0);
    in_full       = (in_count == IN_CW'(IN_DEPTH));
    out_empty     = (out_count == '0);
    out_full      = (out_count == OUT_CW'(OUT_DEPTH));
    in_head       = in_mem[in_rptr];
    do_pop        = last_comb && !in_empty;
    // A pop in the same cycle frees the slot a write into a full FIFO needs
    do_write      = roadid_we && (!in_full || do_pop);
    do_read       = roadid_re && !out_empty;
    do_copy       = best && !in_empty && (!out_full || do_read);
    set_overflow  = (roadid_we && !do_write) || (best && !in_empty && !do_copy);
    set_underflow = (last_comb && in_empty) || (best && in_empty) ||
                    (roadid_re && out_empty);
    fifo_roadid_afull = ((IN_CW + 1)'(IN_DEPTH) - {1'b0, in_count}) <=
                        (IN_CW + 1)'(AFULL_MARGIN);
  end

  // Road-ID capture register
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n)  roadid_register <= '0;
    else if (CE)   roadid_register <= ROADID_IN;
  end

  // FIFO storage arrays; contents are meaningless once pointers are reset
  always_ff @(posedge CLOCK) begin
    if (do_write) in_mem[in_wptr]   <= {roadid_register, road_errors_in};
    if (do_copy)  out_mem[out_wptr] <= in_head;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      in_count <= '0;
    end else begin
      if (do_write) in_wptr <= in_wptr + IN_AW'(1);
      if (do_pop)   in_rptr <= in_rptr + IN_AW'(1);
      if (do_write && !do_pop)      in_count <= in_count + IN_CW'(1);
      else if (do_pop && !do_write) in_count <= in_count - IN_CW'(1);
    end
  end

  // Output FIFO pointers and occupancy; pointers wrap at OUT_DEPTH
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
    end else begin
      if (do_copy)
        out_wptr <= (out_wptr == OUT_AW'(OUT_DEPTH - 1)) ? '0 : out_wptr + OUT_AW'(1);
      if (do_read)
        out_rptr <= (out_rptr == OUT_AW'(OUT_DEPTH - 1)) ? '0 : out_rptr + OUT_AW'(1);
      if (do_copy && !do_read)      out_count <= out_count + OUT_CW'(1);
      else if (do_read && !do_copy) out_count <= out_count - OUT_CW'(1);
    end
  end

  // Registered output data with a one-cycle valid pulse per accepted read
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      ROADID_OUT      <= '0;
      road_errors_out <= '0;
      roadid_valid    <= 1'b0;
    end else begin
      roadid_valid <= do_read;
      if (do_read) {ROADID_OUT, road_errors_out} <= out_mem[out_rptr];
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (set_overflow)  overflow_err  <= 1'b1;
      else if (clr_err)  overflow_err  <= 1'b0;
      if (set_underflow) underflow_err <= 1'b1;
      else if (clr_err)  underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roadid_pass_param.sv
// Directed bench for roadid_pass_param (output FIFO depth 2 to reach full).
module tb_roadid_pass_param;

  localparam int ID_W = 21;
  localparam int ERR_W = 2;

  logic             CLOCK = 1'b0;
  logic             reset_n = 1'b0;
  logic             CE = 1'b0;
  logic [ID_W-1:0]  ROADID_IN = '0;
  logic [ERR_W-1:0] road_errors_in = '0;
  logic             roadid_we = 1'b0;
  logic             last_comb = 1'b0;
  logic             best = 1'b0;
  logic             roadid_re = 1'b0;
  logic             clr_err = 1'b0;
  logic [ID_W-1:0]  ROADID_OUT;
  logic [ERR_W-1:0] road_errors_out;
  logic             roadid_valid;
  logic             fifo_roadid_afull;
  logic [4:0]       in_count;
  logic [1:0]       out_count;
  logic             overflow_err;
  logic             underflow_err;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  roadid_pass_param #(
    .ID_W(ID_W), .ERR_W(ERR_W), .IN_DEPTH(16), .OUT_DEPTH(2), .AFULL_MARGIN(2)
  ) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .CE(CE), .ROADID_IN(ROADID_IN),
    .road_errors_in(road_errors_in), .roadid_we(roadid_we), .last_comb(last_comb),
    .best(best), .roadid_re(roadid_re), .clr_err(clr_err),
    .ROADID_OUT(ROADID_OUT), .road_errors_out(road_errors_out),
    .roadid_valid(roadid_valid), .fifo_roadid_afull(fifo_roadid_afull),
    .in_count(in_count), .out_count(out_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and sample 1 ns later
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Capture id into the register, then push it with err bits
  task automatic push(input logic [ID_W-1:0] id, input logic [ERR_W-1:0] err);
    CE = 1'b1; ROADID_IN = id;
    tick();
    CE = 1'b0; roadid_we = 1'b1; road_errors_in = err;
    tick();
    roadid_we = 1'b0;
  endtask

  task automatic ops(input logic b, input logic lc, input logic re, input logic clr);
    best = b; last_comb = lc; roadid_re = re; clr_err = clr;
    tick();
    best = 1'b0; last_comb = 1'b0; roadid_re = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_in_count", 32'(in_count), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_valid", 32'(roadid_valid), 0);
    check("rst_out", 32'(ROADID_OUT), 0);
    check("rst_afull", 32'(fifo_roadid_afull), 0);
    check("rst_flags", {30'd0, overflow_err, underflow_err}, 0);
    #3 reset_n = 1'b1;

    // Single road end to end
    push(21'h1ABCDE, 2'b01);
    check("single_in_count", 32'(in_count), 1);
    ops(1, 1, 0, 0);
    check("single_in_after_copy", 32'(in_count), 0);
    check("single_out_after_copy", 32'(out_count), 1);
    ops(0, 0, 1, 0);
    check("single_valid", 32'(roadid_valid), 1);
    check("single_id", 32'(ROADID_OUT), 32'h1ABCDE);
    check("single_err", 32'(road_errors_out), 1);
    check("single_out_count", 32'(out_count), 0);
    tick();
    check("single_valid_pulse", 32'(roadid_valid), 0);
    check("single_hold", 32'(ROADID_OUT), 32'h1ABCDE);

    // Fill the input FIFO to its almost-full and full boundaries
    for (int i = 0; i < 13; i++) push(21'(32'h100 + i), 2'(i));
    check("fill13_afull", 32'(fifo_roadid_afull), 0);
    push(21'h10D, 2'd1);
    check("fill14_afull", 32'(fifo_roadid_afull), 1);
    check("fill14_count", 32'(in_count), 14);
    push(21'h10E, 2'd2);
    push(21'h10F, 2'd3);
    check("fill16_count", 32'(in_count), 16);
    check("fill16_no_ovf", 32'(overflow_err), 0);
    push(21'h1FF, 2'd0);
    check("fill17_count", 32'(in_count), 16);
    check("fill17_ovf", 32'(overflow_err), 1);
    // Write plus pop on a full FIFO: pops 0x100, appends 0x2AA
    CE = 1'b1; ROADID_IN = 21'h2AA;
    tick();
    CE = 1'b0; roadid_we = 1'b1; road_errors_in = 2'b10; last_comb = 1'b1;
    tick();
    roadid_we = 1'b0; last_comb = 1'b0;
    check("full_wr_pop_count", 32'(in_count), 16);
    ops(0, 0, 0, 1);
    check("ovf_cleared", 32'(overflow_err), 0);
    ops(1, 1, 0, 0);
    ops(0, 0, 1, 0);
    check("fill_head_id", 32'(ROADID_OUT), 32'h101);
    check("fill_head_err", 32'(road_errors_out), 1);
    for (int i = 0; i < 14; i++) ops(0, 1, 0, 0);
    check("drain_count", 32'(in_count), 1);
    check("drain_afull", 32'(fifo_roadid_afull), 0);
    ops(1, 1, 0, 0);
    ops(0, 0, 1, 0);
    check("wrap_id", 32'(ROADID_OUT), 32'h2AA);
    check("wrap_err", 32'(road_errors_out), 2);
    check("wrap_in_empty", 32'(in_count), 0);

    // Only the best road of three reaches the output FIFO
    push(21'h0AAAA1, 2'd0);
    push(21'h0BBBB2, 2'd3);
    push(21'h0CCCC3, 2'd1);
    ops(0, 1, 0, 0);
    ops(1, 1, 0, 0);
    ops(0, 1, 0, 0);
    check("nb_out_count", 32'(out_count), 1);
    check("nb_in_count", 32'(in_count), 0);
    ops(0, 0, 1, 0);
    check("nb_id", 32'(ROADID_OUT), 32'h0BBBB2);
    check("nb_err", 32'(road_errors_out), 3);

    // Operations on empty FIFOs
    ops(0, 1, 0, 0);
    check("empty_pop_udf", 32'(underflow_err), 1);
    check("empty_pop_count", 32'(in_count), 0);
    ops(0, 0, 0, 1);
    check("udf_clear", 32'(underflow_err), 0);
    ops(1, 0, 0, 0);
    check("empty_best_udf", 32'(underflow_err), 1);
    check("empty_best_out", 32'(out_count), 0);
    ops(0, 0, 0, 1);
    ops(0, 0, 1, 0);
    check("empty_read_udf", 32'(underflow_err), 1);
    check("empty_read_valid", 32'(roadid_valid), 0);
    check("empty_read_hold", 32'(ROADID_OUT), 32'h0BBBB2);
    ops(0, 1, 0, 1);
    check("udf_set_beats_clr", 32'(underflow_err), 1);
    ops(0, 0, 0, 1);
    check("udf_clear2", 32'(underflow_err), 0);

    // Output FIFO full
    push(21'h0D0001, 2'd1);
    push(21'h0E0002, 2'd2);
    push(21'h0F0003, 2'd3);
    ops(1, 1, 0, 0);
    ops(1, 1, 0, 0);
    check("ofull_count", 32'(out_count), 2);
    check("ofull_no_ovf", 32'(overflow_err), 0);
    ops(1, 1, 0, 0);
    check("ofull_drop_count", 32'(out_count), 2);
    check("ofull_ovf", 32'(overflow_err), 1);
    check("ofull_in_count", 32'(in_count), 0);
    ops(0, 0, 1, 0);
    check("ofull_rd1", 32'(ROADID_OUT), 32'h0D0001);
    ops(0, 0, 1, 0);
    check("ofull_rd2", 32'(ROADID_OUT), 32'h0E0002);
    check("ofull_rd2_err", 32'(road_errors_out), 2);
    check("ofull_drained", 32'(out_count), 0);
    // Copy and read together while full are both accepted
    push(21'h111111, 2'd0);
    push(21'h122222, 2'd1);
    push(21'h133333, 2'd2);
    ops(1, 1, 0, 0);
    ops(1, 1, 0, 0);
    ops(0, 0, 0, 1);
    ops(1, 1, 1, 0);
    check("full_cr_valid", 32'(roadid_valid), 1);
    check("full_cr_id", 32'(ROADID_OUT), 32'h111111);
    check("full_cr_count", 32'(out_count), 2);
    check("full_cr_no_ovf", 32'(overflow_err), 0);
    ops(0, 0, 1, 0);
    check("full_cr_rd2", 32'(ROADID_OUT), 32'h122222);
    ops(0, 0, 1, 0);
    check("full_cr_rd3", 32'(ROADID_OUT), 32'h133333);

    // Asynchronous reset mid-stream
    push(21'h0ABCD1, 2'd1);
    push(21'h0ABCD2, 2'd2);
    ops(1, 1, 0, 0);
    ops(0, 0, 0, 0);
    ops(0, 1, 1, 0);
    check("pre_rst_out", 32'(ROADID_OUT), 32'h0ABCD1);
    ops(1, 0, 1, 0);
    check("pre_rst_udf", 32'(underflow_err), 1);
    check("pre_rst_in", 32'(in_count), 0);
    push(21'h0ABCD3, 2'd3);
    ops(1, 0, 0, 0);
    check("pre_rst_both", {in_count, 1'b0, out_count}, {5'd1, 1'b0, 2'd1});
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_count", 32'(in_count), 0);
    check("arst_out_count", 32'(out_count), 0);
    check("arst_out", 32'(ROADID_OUT), 0);
    check("arst_flags", {30'd0, overflow_err, underflow_err}, 0);
    check("arst_valid", 32'(roadid_valid), 0);
    #1 reset_n = 1'b1;
    ops(0, 0, 1, 0);
    check("post_rst_udf", 32'(underflow_err), 1);
    check("post_rst_valid", 32'(roadid_valid), 0);
    check("post_rst_out", 32'(ROADID_OUT), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
